// File: rtl/param_sync_fifo.sv
// ---------------------------------------------------------------------------
// param_sync_fifo
//
// Parametrised single-clock synchronous FIFO with occupancy count,
// programmable almost-full / almost-empty thresholds, sticky overflow /
// underflow flags and an optional first-word-fall-through read mode.
//
// Build option:
//   PARAM_SYNC_FIFO_FWFT_EN  defined   -> first-word-fall-through read mode
//                            undefined -> registered read (1-cycle latency)
//
// Parameters:
//   WIDTH     data word width (>= 1)
//   DEPTH     number of entries (>= 2, need not be a power of two)
//   AF_LEVEL  almost_full  when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  almost_empty when count <= AE_LEVEL (0..DEPTH-1)
//
// Ports:
//   clk           clock, all logic on posedge
//   rst           synchronous active-high reset
//   wr_en         write request
//   rd_en         read request (pop in FWFT mode)
//   data_in       write data
//   data_out      read data
//   empty         count == 0
//   full          count == DEPTH
//   almost_empty  count <= AE_LEVEL
//   almost_full   count >= AF_LEVEL
//   count         current occupancy, 0..DEPTH
//   overflow      sticky: a write was rejected
//   underflow     sticky: a read was rejected
// ---------------------------------------------------------------------------
module param_sync_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 63,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_L     = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_L     = CW'(AE_LEVEL);

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_empty;
    logic          r_full;
    logic          r_almost_empty;
    logic          r_almost_full;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_rd_acc;
    logic          w_wr_acc;
    logic [CW-1:0] w_count_nxt;

    // Explicit wrap so non-power-of-two depths never rely on rollover.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // At full, a same-cycle read frees the slot the write needs.
    assign w_rd_acc = rd_en && !r_empty;
    assign w_wr_acc = wr_en && (!r_full || w_rd_acc);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Flags are derived from the next count so they always agree with count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= (AF_L == '0);
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count        <= w_count_nxt;
            r_empty        <= (w_count_nxt == '0);
            r_full         <= (w_count_nxt == CNT_FULL);
            r_almost_empty <= (w_count_nxt <= AE_L);
            r_almost_full  <= (w_count_nxt >= AF_L);
            if (wr_en && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && !w_rd_acc) begin
                r_underflow <= 1'b1;
            end
        end
    end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    // Head entry is shown directly from registered state; zero while empty.
    assign data_out = r_empty ? '0 : r_mem[r_rd_ptr];
`else
    logic [WIDTH-1:0] r_data_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
        end else if (w_rd_acc) begin
            r_data_out <= r_mem[r_rd_ptr];
        end
    end

    assign data_out = r_data_out;
`endif

    assign empty        = r_empty;
    assign full         = r_full;
    assign almost_empty = r_almost_empty;
    assign almost_full  = r_almost_full;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_param_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_param_sync_fifo
//
// Directed self-checking bench for param_sync_fifo at DEPTH=5,
// AF_LEVEL=4, AE_LEVEL=1. Honours PARAM_SYNC_FIFO_FWFT_EN to select the
// matching scenario set.
// ---------------------------------------------------------------------------
module tb_param_sync_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 5;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    int n_checks = 0;
    int n_errors = 0;

    param_sync_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (4),
        .AE_LEVEL (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .data_in      (data_in),
        .data_out     (data_out),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then settle 1 time unit past the edge.
    task automatic cyc(input logic r, input logic w, input logic rd,
                       input logic [WIDTH-1:0] d);
        @(negedge clk);
        rst     = r;
        wr_en   = w;
        rd_en   = rd;
        data_in = d;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset;
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if (count !== 3'd0 || empty !== 1'b1 || almost_empty !== 1'b1 ||
            full !== 1'b0 || almost_full !== 1'b0 || overflow !== 1'b0 ||
            underflow !== 1'b0 || data_out !== 8'h00) begin
            n_errors++;
            $display("FAIL reset: count=%0d e=%b ae=%b f=%b af=%b ov=%b uf=%b dout=%02h exp count=0 e=1 ae=1 f=0 af=0 ov=0 uf=0 dout=00",
                     count, empty, almost_empty, full, almost_full, overflow, underflow, data_out);
        end
    endtask

    task automatic test_fill_drain;
        logic [WIDTH-1:0] exp_d;
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            exp_d = 8'h11 + 8'(i);
            cyc(1'b0, 1'b1, 1'b0, exp_d);
            n_checks++;
            if (count !== CW'(i + 1) || full !== (i == 4) ||
                almost_full !== (i >= 3) || almost_empty !== (i == 0) ||
                empty !== 1'b0) begin
                n_errors++;
                $display("FAIL fill[%0d]: count=%0d f=%b af=%b ae=%b e=%b exp count=%0d f=%b af=%b ae=%b e=0",
                         i, count, full, almost_full, almost_empty, empty,
                         i + 1, (i == 4), (i >= 3), (i == 0));
            end
        end
        cyc(1'b0, 1'b1, 1'b0, 8'h99);
        n_checks++;
        if (overflow !== 1'b1 || count !== 3'd5 || underflow !== 1'b0) begin
            n_errors++;
            $display("FAIL overflow: ov=%b count=%0d uf=%b exp ov=1 count=5 uf=0",
                     overflow, count, underflow);
        end
        for (int i = 0; i < 5; i++) begin
            exp_d = 8'h11 + 8'(i);
            cyc(1'b0, 1'b0, 1'b1, 8'h00);
            n_checks++;
            if (data_out !== exp_d || count !== CW'(4 - i) || empty !== (i == 4)) begin
                n_errors++;
                $display("FAIL drain[%0d]: dout=%02h count=%0d e=%b exp dout=%02h count=%0d e=%b",
                         i, data_out, count, empty, exp_d, 4 - i, (i == 4));
            end
        end
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        n_checks++;
        if (underflow !== 1'b1 || data_out !== 8'h15 || count !== 3'd0 || empty !== 1'b1) begin
            n_errors++;
            $display("FAIL underflow: uf=%b dout=%02h count=%0d e=%b exp uf=1 dout=15 count=0 e=1",
                     underflow, data_out, count, empty);
        end
    endtask

    task automatic test_wrap;
        logic [WIDTH-1:0] exp_d;
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 3; k++) begin
                cyc(1'b0, 1'b1, 1'b0, 8'(8'h40 + 16 * r + k));
            end
            n_checks++;
            if (count !== 3'd3) begin
                n_errors++;
                $display("FAIL wrap_count[%0d]: count=%0d exp 3", r, count);
            end
            for (int k = 0; k < 3; k++) begin
                exp_d = 8'(8'h40 + 16 * r + k);
                cyc(1'b0, 1'b0, 1'b1, 8'h00);
                n_checks++;
                if (data_out !== exp_d) begin
                    n_errors++;
                    $display("FAIL wrap_data[%0d.%0d]: dout=%02h exp %02h", r, k, data_out, exp_d);
                end
            end
        end
        n_checks++;
        if (empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_end: e=%b ov=%b uf=%b exp e=1 ov=0 uf=0", empty, overflow, underflow);
        end
    endtask

    task automatic test_full_rw;
        logic [WIDTH-1:0] exp_d;
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'h21 + 8'(i));
        end
        cyc(1'b0, 1'b1, 1'b1, 8'hA5);
        n_checks++;
        if (count !== 3'd5 || full !== 1'b1 || overflow !== 1'b0 || data_out !== 8'h21) begin
            n_errors++;
            $display("FAIL full_rw: count=%0d f=%b ov=%b dout=%02h exp count=5 f=1 ov=0 dout=21",
                     count, full, overflow, data_out);
        end
        for (int i = 0; i < 5; i++) begin
            exp_d = (i == 4) ? 8'hA5 : 8'h22 + 8'(i);
            cyc(1'b0, 1'b0, 1'b1, 8'h00);
            n_checks++;
            if (data_out !== exp_d) begin
                n_errors++;
                $display("FAIL full_rw_drain[%0d]: dout=%02h exp %02h", i, data_out, exp_d);
            end
        end
    endtask

    task automatic test_empty_rw;
        logic [WIDTH-1:0] exp_d;
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        exp_d = 8'h3C;
`else
        exp_d = 8'h00;
`endif
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 8'h3C);
        n_checks++;
        if (underflow !== 1'b1 || count !== 3'd1 || empty !== 1'b0 ||
            overflow !== 1'b0 || data_out !== exp_d) begin
            n_errors++;
            $display("FAIL empty_rw: uf=%b count=%0d e=%b ov=%b dout=%02h exp uf=1 count=1 e=0 ov=0 dout=%02h",
                     underflow, count, empty, overflow, data_out, exp_d);
        end
    endtask

    task automatic test_reset_mid;
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'h60 + 8'(i));
        end
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        n_checks++;
        if (count !== 3'd3 || overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_pre: count=%0d ov=%b exp count=3 ov=1", count, overflow);
        end
        cyc(1'b1, 1'b1, 1'b0, 8'h55);
        n_checks++;
        if (count !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0 || data_out !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_mid: count=%0d e=%b ov=%b dout=%02h exp count=0 e=1 ov=0 dout=00",
                     count, empty, overflow, data_out);
        end
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if (count !== 3'd0 || empty !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_drop: count=%0d e=%b exp count=0 e=1", count, empty);
        end
    endtask

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    task automatic test_fwft;
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h7E);
        n_checks++;
        if (empty !== 1'b0 || data_out !== 8'h7E) begin
            n_errors++;
            $display("FAIL fwft_show: e=%b dout=%02h exp e=0 dout=7e", empty, data_out);
        end
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        n_checks++;
        if (empty !== 1'b1 || data_out !== 8'h00 || underflow !== 1'b0) begin
            n_errors++;
            $display("FAIL fwft_pop: e=%b dout=%02h uf=%b exp e=1 dout=00 uf=0",
                     empty, data_out, underflow);
        end
    endtask
`endif

    initial begin
        rst     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        test_reset;
        test_empty_rw;
        test_reset_mid;
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        test_fwft;
`else
        test_fill_drain;
        test_wrap;
        test_full_rw;
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
